// File: rtl/core_dbg_pkg.sv
// Shared definitions for the core debug controller: state and opcode
// encodings, status word layout and the default LA command key.
package core_dbg_pkg;

  typedef enum logic [1:0] {
    ST_RESETTING = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT      = 2'd2,
    ST_STEP      = 2'd3
  } dbg_state_e;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_RUN        = 3'd1,
    OP_HALT       = 3'd2,
    OP_STEP       = 3'd3,
    OP_SET_BP     = 3'd4,
    OP_CLR_BP     = 3'd5,
    OP_RESET_CORE = 3'd6,
    OP_CLR_STATUS = 3'd7
  } dbg_op_e;

  localparam logic [31:0] CMD_KEY_DEFAULT = 32'hFFFF_FFF0;

  localparam int unsigned STAT_STATE_LSB   = 0;
  localparam int unsigned STAT_BP_HIT      = 2;
  localparam int unsigned STAT_BP_EN       = 3;
  localparam int unsigned STAT_CMD_ERR     = 4;
  localparam int unsigned STAT_CMD_CNT_LSB = 8;
  localparam int unsigned STAT_STEP_LSB    = 16;

endpackage

// File: rtl/la_cmd_decoder.sv
// Detects a toggle of la_data_in[31] qualified by the LA enable key and
// splits the command word into opcode and operand.
module la_cmd_decoder
  import core_dbg_pkg::*;
#(
  parameter logic [31:0] CMD_KEY = CMD_KEY_DEFAULT
) (
  input  logic        clk,
  input  logic [31:0] la_data_in,
  input  logic [31:0] la_oenb,
  output logic        cmd_valid,
  output dbg_op_e     opcode,
  output logic [27:0] operand
);

  logic strobe_q;

  // Tracks the strobe bit in reset as well, so a static level never fires.
  always_ff @(posedge clk) begin
    strobe_q <= la_data_in[31];
  end

  always_comb begin
    cmd_valid = (la_data_in[31] != strobe_q) && (la_oenb == CMD_KEY);
    opcode    = dbg_op_e'(la_data_in[30:28]);
    operand   = la_data_in[27:0];
  end

endmodule

// File: rtl/core_debug_ctrl.sv
// Run/halt/step/breakpoint controller for a core, driven by LA command
// words and reporting a registered status word.
module core_debug_ctrl
  import core_dbg_pkg::*;
#(
  parameter int unsigned N_STALL   = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned RST_PULSE = 4,
  parameter bit          BOOT_HALT = 1'b0,
  parameter logic [31:0] CMD_KEY   = CMD_KEY_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_STALL-1:0] stall_req_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [31:0]        la_data_in,
  input  logic [31:0]        la_oenb,
  output logic               stall_o,
  output logic               core_reset_o,
  output logic [31:0]        la_data_out
);

  localparam int unsigned RCW = $clog2(RST_PULSE + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_PULSE - 1);

  dbg_state_e        state, rst_target;
  logic [RCW-1:0]    rst_cnt;
  logic [STEP_W-1:0] step_cnt, step_load;
  logic [XLEN-1:0]   bp_addr, skip_pc;
  logic              bp_en, bp_skip, bp_hit, cmd_err, bp_match;
  logic [7:0]        cmd_cnt;
  logic [31:0]       status_d;
  logic              cmd_valid;
  dbg_op_e           opcode;
  logic [27:0]       operand;

  la_cmd_decoder #(.CMD_KEY(CMD_KEY)) u_dec (
    .clk        (clk),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .cmd_valid  (cmd_valid),
    .opcode     (opcode),
    .operand    (operand)
  );

  always_comb begin
    step_load    = STEP_W'(operand);
    bp_match     = ((state == ST_RUN) || (state == ST_STEP)) && bp_en &&
                   (pc_i == bp_addr) && !bp_skip;
    stall_o      = (|stall_req_i) || (state == ST_RESETTING) ||
                   (state == ST_HALT) || bp_match;
    core_reset_o = (state == ST_RESETTING);
    status_d                              = '0;
    status_d[STAT_STATE_LSB +: 2]         = state;
    status_d[STAT_BP_HIT]                 = bp_hit;
    status_d[STAT_BP_EN]                  = bp_en;
    status_d[STAT_CMD_ERR]                = cmd_err;
    status_d[STAT_CMD_CNT_LSB +: 8]       = cmd_cnt;
    status_d[STAT_STEP_LSB +: 16]         = 16'(step_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RESETTING;
      rst_target  <= BOOT_HALT ? ST_HALT : ST_RUN;
      rst_cnt     <= '0;
      step_cnt    <= '0;
      bp_addr     <= '0;
      skip_pc     <= '0;
      bp_en       <= 1'b0;
      bp_skip     <= 1'b0;
      bp_hit      <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_cnt     <= '0;
      la_data_out <= '0;
    end else begin
      la_data_out <= status_d;
      if (cmd_valid) cmd_cnt <= cmd_cnt + 8'd1;
      if (bp_skip && (pc_i != skip_pc)) bp_skip <= 1'b0;

      if (state == ST_RESETTING) begin
        if (cmd_valid && (opcode != OP_NOP)) cmd_err <= 1'b1;
        if (rst_cnt == RST_LAST) state <= rst_target;
        else                     rst_cnt <= rst_cnt + RCW'(1);
      end else begin
        // Ordered by priority: later assignments (commands) override the
        // step progression and the breakpoint transition.
        if ((state == ST_STEP) && !stall_o) begin
          step_cnt <= step_cnt - STEP_W'(1);
          if (step_cnt == STEP_W'(1)) state <= ST_HALT;
        end
        if (bp_match && !cmd_valid) begin
          state  <= ST_HALT;
          bp_hit <= 1'b1;
        end
        if (cmd_valid) begin
          case (opcode)
            OP_RUN: begin
              state <= ST_RUN;
              if ((state == ST_HALT) || bp_match) begin
                bp_skip <= 1'b1;
                skip_pc <= pc_i;
              end
            end
            OP_HALT: begin
              state <= ST_HALT;
              if (bp_match) bp_hit <= 1'b1;
            end
            OP_STEP: begin
              if (step_load != '0) begin
                step_cnt <= step_load;
                state    <= ST_STEP;
                // Stepping off a halted breakpoint must not re-trigger it.
                if (state == ST_HALT) begin
                  bp_skip <= 1'b1;
                  skip_pc <= pc_i;
                end
              end
            end
            OP_SET_BP: begin
              bp_addr <= XLEN'({operand, 2'b00});
              bp_en   <= 1'b1;
            end
            OP_CLR_BP: bp_en <= 1'b0;
            OP_RESET_CORE: begin
              state      <= ST_RESETTING;
              rst_target <= ST_HALT;
              rst_cnt    <= '0;
              step_cnt   <= '0;
            end
            OP_CLR_STATUS: begin
              bp_hit  <= 1'b0;
              cmd_err <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
